// File: rtl/lfo_pkg.sv
// Shared types, default parameters and small helpers for the LFO controller.
package lfo_pkg;

    typedef enum logic [1:0] {
        PRIME,
        RUN,
        RAMP_DOWN,
        HALT
    } lfo_state_t;

    localparam int CODE_W              = 4;
    localparam int DEF_DEBOUNCE_TICKS  = 441;
    localparam int DEF_RAMP_TICKS      = 64;
    localparam int DEF_PRIME_UPDATES   = 3;

    // Width of a counter that holds 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One LSB toward the target, never past it.
    function automatic logic [CODE_W-1:0] step_toward(input logic [CODE_W-1:0] cur,
                                                      input logic [CODE_W-1:0] tgt);
        if (cur < tgt) begin
            return cur + 1'b1;
        end else if (cur > tgt) begin
            return cur - 1'b1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/lfo_debounce.sv
// Synchroniser plus tick-counted debouncer for one 4-bit switch field.
module lfo_debounce
    import lfo_pkg::*;
#(
    parameter int TICKS = DEF_DEBOUNCE_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sampleTick,
    input  logic [CODE_W-1:0] raw,
    output logic [CODE_W-1:0] stable
);

    localparam int            CW       = cnt_width(TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICKS - 1);

    logic [CODE_W-1:0] sync_meta;
    logic [CODE_W-1:0] sync_out;
    logic [CODE_W-1:0] candidate;
    logic [CODE_W-1:0] target;
    logic [CW-1:0]     cnt;
    logic              accept;

    // The tick that completes the stability window promotes the candidate.
    assign accept = !reset && sampleTick && (sync_out == candidate) && (cnt == CNT_LAST);

    // Look-ahead output so a ramp step on the accepting edge already uses the new value.
    assign stable = accept ? candidate : target;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make both flops sample pre-edge values, forming a real two-stage chain.
        if (reset) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // Candidate tracking, saturating stability counter and accepted target.
    always_ff @(posedge clk) begin
        if (reset) begin
            candidate <= '0;
            cnt       <= '0;
            target    <= '0;
        end else if (sync_out != candidate) begin
            candidate <= sync_out;
            cnt       <= '0;
        end else if (sampleTick) begin
            if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                target <= candidate;
            end
        end
    end

endmodule

// File: rtl/lfo_ctrl.sv
// LFO sequencing: prime flush, pulse generation, depth ramping and clean stop/restart.
module lfo_ctrl
    import lfo_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int RAMP_TICKS     = DEF_RAMP_TICKS,
    parameter int PRIME_UPDATES  = DEF_PRIME_UPDATES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sampleTick,
    input  logic              lfoEnable,
    input  logic [CODE_W-1:0] freqReq,
    input  logic [CODE_W-1:0] depthReq,
    output logic [CODE_W-1:0] freqSetting,
    output logic [CODE_W-1:0] scaleFactor,
    output logic              FIFOupdate,
    output logic              lfoActive,
    output logic              rampBusy
);

    localparam int            RW         = cnt_width(RAMP_TICKS);
    localparam int            PW         = cnt_width(PRIME_UPDATES);
    localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_TICKS - 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_UPDATES - 1);

    lfo_state_t        state;
    lfo_state_t        state_next;
    logic [CODE_W-1:0] freq_target;
    logic [CODE_W-1:0] depth_target;
    logic [CODE_W-1:0] eff_target;
    logic [RW-1:0]     ramp_cnt;
    logic [PW-1:0]     prime_cnt;
    logic              pulse;
    logic              ramping;
    logic              ramp_wrap;

    lfo_debounce #(.TICKS(DEBOUNCE_TICKS)) u_freq_db (
        .clk        (clk),
        .reset      (reset),
        .sampleTick (sampleTick),
        .raw        (freqReq),
        .stable     (freq_target)
    );

    lfo_debounce #(.TICKS(DEBOUNCE_TICKS)) u_depth_db (
        .clk        (clk),
        .reset      (reset),
        .sampleTick (sampleTick),
        .raw        (depthReq),
        .stable     (depth_target)
    );

    // Disabling modulation retargets the ramp to zero immediately.
    assign eff_target = lfoEnable ? depth_target : '0;
    assign pulse      = sampleTick && (state != HALT);
    assign ramping    = sampleTick && ((state == RUN) || (state == RAMP_DOWN));
    assign ramp_wrap  = ramping && (ramp_cnt == RAMP_LAST);
    assign lfoActive  = (state == RUN) || (state == RAMP_DOWN);
    assign rampBusy   = (scaleFactor != eff_target);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PRIME;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            PRIME: begin
                if (sampleTick && (prime_cnt == PRIME_LAST)) begin
                    state_next = lfoEnable ? RUN : HALT;
                end
            end
            RUN: begin
                if (!lfoEnable) begin
                    state_next = RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                if (lfoEnable) begin
                    state_next = RUN;
                end else if (scaleFactor == '0) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (lfoEnable) begin
                    state_next = RUN;
                end
            end
            default: state_next = PRIME;
        endcase
    end

    // Pulse, code registers and counters; codes move only on a pulse-issuing edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            freqSetting <= '0;
            scaleFactor <= '0;
            FIFOupdate  <= 1'b0;
            ramp_cnt    <= '0;
            prime_cnt   <= '0;
        end else begin
            FIFOupdate <= pulse;
            if (pulse) begin
                freqSetting <= freq_target;
            end
            if ((state == PRIME) && sampleTick && (prime_cnt != PRIME_LAST)) begin
                prime_cnt <= prime_cnt + 1'b1;
            end
            if (state == HALT) begin
                ramp_cnt <= '0;
            end else if (ramping) begin
                ramp_cnt <= ramp_wrap ? '0 : ramp_cnt + 1'b1;
            end
            if (ramp_wrap) begin
                scaleFactor <= step_toward(scaleFactor, eff_target);
            end
        end
    end

endmodule

// File: tb/tb_lfo_ctrl.sv
// Self-checking bench for lfo_ctrl: directed table, corner sequences, random run vs reference model.
module tb_lfo_ctrl;

    localparam int T = 4;
    localparam int R = 2;
    localparam int P = 3;

    localparam int M_PRIME = 0;
    localparam int M_RUN   = 1;
    localparam int M_DOWN  = 2;
    localparam int M_HALT  = 3;

    logic       clk = 1'b0;
    logic       in_reset, in_tick, in_en;
    logic [3:0] in_f, in_d;
    logic [3:0] freqSetting, scaleFactor;
    logic       FIFOupdate, lfoActive, rampBusy;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;

    lfo_ctrl #(.DEBOUNCE_TICKS(T), .RAMP_TICKS(R), .PRIME_UPDATES(P)) dut (
        .clk         (clk),
        .reset       (in_reset),
        .sampleTick  (in_tick),
        .lfoEnable   (in_en),
        .freqReq     (in_f),
        .depthReq    (in_d),
        .freqSetting (freqSetting),
        .scaleFactor (scaleFactor),
        .FIFOupdate  (FIFOupdate),
        .lfoActive   (lfoActive),
        .rampBusy    (rampBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    // Switch path: raw history (two-cycle delay), last seen value, ticks it has stayed put.
    typedef struct {
        logic [3:0] h0;
        logic [3:0] h1;
        logic [3:0] last;
        logic [3:0] tgt;
        int         run;
    } db_t;

    db_t        m_f, m_d;
    int         m_mode, m_primed, m_ramp;
    logic [3:0] m_freq, m_scale;
    logic       m_fifo;
    bit         m_valid = 0;
    bit         m_last_reset = 0;
    logic [3:0] prev_f, prev_s;

    function automatic db_t db_next(db_t db, logic [3:0] raw, logic tk);
        db_t n;
        n = db;
        if (db.h1 != db.last) begin
            n.last = db.h1;
            n.run  = 0;
        end else if (tk) begin
            if (n.run < T) n.run = n.run + 1;
            if (n.run >= T) n.tgt = n.last;
        end
        n.h1 = db.h0;
        n.h0 = raw;
        return n;
    endfunction

    // Depth target as it will be seen on the coming edge (accepted value counts at once).
    function automatic logic exp_busy();
        logic [3:0] tgt;
        tgt = m_d.tgt;
        if (!in_reset && in_tick && (m_d.h1 == m_d.last) && (m_d.run >= T - 1)) tgt = m_d.last;
        return m_scale != (in_en ? tgt : 4'd0);
    endfunction

    task automatic model_edge();
        logic [3:0] eff, old_scale;
        logic       pulse;
        m_last_reset = in_reset;
        if (in_reset) begin
            m_f = '{default: 0};
            m_d = '{default: 0};
            m_mode = M_PRIME; m_primed = 0; m_ramp = 0;
            m_freq = 0; m_scale = 0; m_fifo = 0;
            m_valid = 1;
            return;
        end
        m_f = db_next(m_f, in_f, in_tick);
        m_d = db_next(m_d, in_d, in_tick);
        eff = in_en ? m_d.tgt : 4'd0;
        pulse = in_tick && (m_mode != M_HALT);
        old_scale = m_scale;
        case (m_mode)
            M_PRIME: begin
                if (in_tick) begin
                    m_primed++;
                    if (m_primed == P) m_mode = in_en ? M_RUN : M_HALT;
                end
            end
            M_RUN, M_DOWN: begin
                if (in_tick) begin
                    m_ramp++;
                    if (m_ramp == R) begin
                        m_ramp = 0;
                        if (m_scale < eff) m_scale = m_scale + 4'd1;
                        else if (m_scale > eff) m_scale = m_scale - 4'd1;
                    end
                end
                if (m_mode == M_RUN) begin
                    if (!in_en) m_mode = M_DOWN;
                end else if (in_en) begin
                    m_mode = M_RUN;
                end else if (old_scale == 0) begin
                    m_mode = M_HALT;
                end
            end
            default: begin
                m_ramp = 0;
                if (in_en) m_mode = M_RUN;
            end
        endcase
        if (pulse) m_freq = m_f.tgt;
        m_fifo = pulse;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        logic [10:0] got, exp;
        int delta;
        @(negedge clk);
        if (m_valid) begin
            got = {freqSetting, scaleFactor, FIFOupdate, lfoActive, rampBusy};
            exp = {m_freq, m_scale, m_fifo, (m_mode == M_RUN) || (m_mode == M_DOWN), exp_busy()};
            check("model", 32'(got), 32'(exp));
            if (!m_last_reset && ((freqSetting != prev_f) || (scaleFactor != prev_s))) begin
                check("code_change_with_pulse", 32'(FIFOupdate), 32'd1);
                delta = int'(scaleFactor) - int'(prev_s);
                check("depth_step_size", 32'((delta >= -1) && (delta <= 1)), 32'd1);
            end
            prev_f = freqSetting;
            prev_s = scaleFactor;
            if (FIFOupdate) pulse_cnt++;
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick_period();
        in_tick = 1'b1;
        step();
        in_tick = 1'b0;
        repeat (7) step();
    endtask

    typedef struct {
        logic       en;
        logic [3:0] f;
        logic [3:0] d;
        int         ticks;
        logic [3:0] exp_freq;
        logic [3:0] exp_scale;
        logic       exp_active;
        logic       exp_busy;
        int         exp_pulses;   // -1: not checked
    } vec_t;

    vec_t vecs[7];
    int   guard;

    initial begin
        // Phases after priming with enable high; expected states follow from the ramp/debounce rules.
        vecs[0] = '{1'b1, 4'd5, 4'd15, 40, 4'd5, 4'd15, 1'b1, 1'b0, 40};  // ramp 0 -> 15
        vecs[1] = '{1'b1, 4'd4, 4'd15, 1,  4'd5, 4'd15, 1'b1, 1'b0, 1};   // one-tick glitch on freq
        vecs[2] = '{1'b1, 4'd5, 4'd15, 8,  4'd5, 4'd15, 1'b1, 1'b0, 8};   // glitch rejected
        vecs[3] = '{1'b1, 4'd5, 4'd6,  30, 4'd5, 4'd6,  1'b1, 1'b0, 30};  // ramp 15 -> 6
        vecs[4] = '{1'b0, 4'd5, 4'd6,  14, 4'd5, 4'd0,  1'b0, 1'b0, -1};  // ramp down 6 -> 0, halt
        vecs[5] = '{1'b0, 4'd9, 4'd6,  6,  4'd5, 4'd0,  1'b0, 1'b0, 0};   // halted: no pulses, freq held
        vecs[6] = '{1'b1, 4'd9, 4'd10, 30, 4'd9, 4'd10, 1'b1, 1'b0, -1};  // restart, ramp 0 -> 10

        in_reset = 1'b1; in_tick = 1'b0; in_en = 1'b1; in_f = 4'd0; in_d = 4'd0;
        step();
        step();
        check("reset_state", 32'({freqSetting, scaleFactor, FIFOupdate, lfoActive, rampBusy}), 32'd0);

        // Priming: one-cycle latency, single-cycle pulse, exactly P pulses before RUN.
        in_reset = 1'b0;
        pulse_cnt = 0;
        in_tick = 1'b1;
        step();
        check("pulse_latency", 32'(FIFOupdate), 32'd1);
        in_tick = 1'b0;
        step();
        check("pulse_width", 32'(FIFOupdate), 32'd0);
        repeat (6) step();
        tick_period();
        check("prime_pulses_2", 32'(pulse_cnt), 32'd2);
        check("prime_not_active", 32'(lfoActive), 32'd0);
        tick_period();
        check("prime_pulses_3", 32'(pulse_cnt), 32'd3);
        check("prime_to_run", 32'(lfoActive), 32'd1);
        check("prime_scale_zero", 32'(scaleFactor), 32'd0);

        for (int i = 0; i < 7; i++) begin
            in_en = vecs[i].en;
            in_f  = vecs[i].f;
            in_d  = vecs[i].d;
            pulse_cnt = 0;
            repeat (vecs[i].ticks) tick_period();
            check($sformatf("vec%0d_freq", i), 32'(freqSetting), 32'(vecs[i].exp_freq));
            check($sformatf("vec%0d_scale", i), 32'(scaleFactor), 32'(vecs[i].exp_scale));
            check($sformatf("vec%0d_active", i), 32'(lfoActive), 32'(vecs[i].exp_active));
            check($sformatf("vec%0d_busy", i), 32'(rampBusy), 32'(vecs[i].exp_busy));
            if (vecs[i].exp_pulses >= 0)
                check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt), 32'(vecs[i].exp_pulses));
        end

        // Re-enable mid ramp-down at depth 3 with target 10: no pulse gap, ramp back up.
        in_en = 1'b0;
        guard = 0;
        while ((scaleFactor != 4'd3) && (guard < 20)) begin
            tick_period();
            guard++;
        end
        check("ramp_down_reached_3", 32'(scaleFactor), 32'd3);
        check("ramp_down_active", 32'(lfoActive), 32'd1);
        in_en = 1'b1;
        pulse_cnt = 0;
        repeat (16) tick_period();
        check("reenable_no_gap", 32'(pulse_cnt), 32'd16);
        check("reenable_scale", 32'(scaleFactor), 32'd10);

        // Reset coincident with a tick during RUN: pulse dropped, outputs cleared.
        in_reset = 1'b1;
        in_tick = 1'b1;
        step();
        check("reset_mid_run", 32'({freqSetting, scaleFactor, FIFOupdate, lfoActive, rampBusy}), 32'd0);
        in_reset = 1'b0;
        in_tick = 1'b0;
        step();
        check("reset_pulse_dropped", 32'(FIFOupdate), 32'd0);

        // Random run: irregular ticks (incl. back-to-back), switch glitches, enable toggles, rare reset.
        for (int c = 0; c < 4000; c++) begin
            in_reset = ($urandom_range(0, 999) == 0);
            in_tick  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) in_en = ~in_en;
            if ($urandom_range(0, 149) == 0) in_f = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) in_d = 4'($urandom_range(0, 15));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfo_ctrl.md
# lfo_ctrl

Sequencing and configuration controller for the LFO generator in the modulation path. It converts the I2S-side sample strobe into the LFO's `FIFOupdate` pulses and synchronises and debounces the DIP-switch rate and depth requests. It ramps depth one LSB at a time to avoid zipper noise, and performs a clean ramp-to-zero stop and restart when modulation is disabled. It sits between the switch/audio-clock domain logic and `freqSetting`/`scaleFactor`/`FIFOupdate` on the LFO.

## Interface
- `DEBOUNCE_TICKS`, default 441: consecutive sample ticks a switch value must be stable before acceptance (441 ticks = 10 ms at 44.1 kHz).
- `RAMP_TICKS`, default 64: sample ticks between successive ±1 depth steps.
- `PRIME_UPDATES`, default 3: update pulses issued after reset to flush the LFO pipeline (phase → LUT → multiply).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `sampleTick` in 1: one-cycle strobe per audio sample.
- `lfoEnable` in 1: modulation enable, level-sensitive.
- `freqReq` in 4: raw rate switches, asynchronous.
- `depthReq` in 4: raw depth switches, asynchronous.
- `freqSetting` out 4: rate code to the LFO.
- `scaleFactor` out 4: depth code to the LFO.
- `FIFOupdate` out 1: one-cycle LFO advance strobe.
- `lfoActive` out 1: high in RUN and RAMP_DOWN.
- `rampBusy` out 1: high when `scaleFactor` differs from the effective depth target.

## Operation
- Each request field passes through a 2-flop synchroniser, then a debouncer.
- Debouncer holds a candidate value and a tick counter:
  - Counter clears whenever the synchronised value differs from the candidate; the candidate then loads the new value.
  - On a `sampleTick` with the counter at `DEBOUNCE_TICKS-1`, the target loads the candidate and the counter saturates.
- The effective depth target is `depthTarget` when `lfoEnable` is high, otherwise 0.
- States:
  - PRIME (reset state): pulse on every tick with `scaleFactor` held at 0. After `PRIME_UPDATES` pulses, go to RUN if `lfoEnable` is high, else HALT.
  - RUN: pulse on every tick. Ramp toward the target. `lfoEnable` low → RAMP_DOWN.
  - RAMP_DOWN: pulse on every tick and ramp toward 0. `lfoEnable` high → RUN. When `scaleFactor`==0 and no step is pending, go to HALT on the next cycle.
  - HALT: no pulses; ramp counter cleared. `freqSetting` and `scaleFactor` are held. `lfoEnable` high → RUN.
- Ramp:
  - The counter advances on each tick in RUN and RAMP_DOWN and wraps at `RAMP_TICKS-1`.
  - On wrap, `scaleFactor` steps ±1 toward the effective target, with no overshoot.
- `freqSetting` loads `freqTarget` only in a cycle where `FIFOupdate` is asserted. It never changes in HALT.
- Simultaneous events:
  - Enable drop coincident with a ramp-up step: the target becomes 0 and the step direction is down.
  - Debounce acceptance coincident with a ramp wrap: the step uses the newly accepted target.
- Arithmetic is unsigned 4-bit for codes. Counter widths use `$clog2` of the parameter and never overflow.

## Timing
- `sampleTick` → `FIFOupdate`: 1 cycle, registered.
- Back-to-back ticks produce back-to-back pulses.
- `freqSetting` and `scaleFactor` change only on the same edge that raises `FIFOupdate`, so the LFO samples coherent values.
- Switch change to accepted target: 2 cycles (sync) plus `DEBOUNCE_TICKS` ticks.
- Full-scale depth ramp: 15 × `RAMP_TICKS` ticks.
- Reset values: `freqSetting`=0, `scaleFactor`=0, `FIFOupdate`=0, `lfoActive`=0, `rampBusy`=0. State is PRIME; targets, candidates, synchronisers and all counters are 0.
- Reset asserted mid-operation: all outputs reach reset values at the next edge, and any pending pulse is dropped.

## Structure
- `lfo_pkg` holds:
  - the `lfo_state_t` enum (PRIME, RUN, RAMP_DOWN, HALT);
  - default localparams for `DEBOUNCE_TICKS`, `RAMP_TICKS` and `PRIME_UPDATES`.
- Sub-module `lfo_debounce` contains the synchroniser, candidate, counter and target for one 4-bit field. It has a `TICKS` parameter and ports `clk`, `reset`, `sampleTick`, `raw`, `stable`. `lfo_ctrl` instantiates it twice.
- `lfo_ctrl` contains the FSM, the ramp counter and the output registers.

## Test plan
All scenarios use `DEBOUNCE_TICKS`=4, `RAMP_TICKS`=2, `PRIME_UPDATES`=3, and a tick every 8 cycles.
- Reset release with `lfoEnable`=1 → exactly 3 `FIFOupdate` pulses with `scaleFactor`=0, then RUN and `lfoActive`=1.
- `depthReq` 0→1111, stable → target accepted after 4 ticks. `scaleFactor` then steps 0,1,…,15, one step every 2 ticks, each step coincident with a pulse. `rampBusy` drops at 15.
- `freqReq`=0101 with a glitch to 0100 lasting 1 tick → the target stays at 0101. `freqSetting` changes only on a `FIFOupdate` cycle.
- `lfoEnable` falls at `scaleFactor`=6 → ramp down 6→0 over 12 ticks, then HALT. No further pulses; `lfoActive`=0; `freqSetting` is held.
- `lfoEnable` rises mid-RAMP_DOWN at `scaleFactor`=3, with target 10 → return to RUN and ramp 3→10 with no pulse gap.
- `reset` asserted during RUN at the same cycle as a `sampleTick` → no pulse is issued, and all outputs are 0 on the next edge.
